// File: rtl/prio_mux_reg.sv
// Registered N-channel select mux with fixed-priority or round-robin arbitration.
// Optional conflict detection/counting is enabled by defining PRIO_MUX_CONFLICT_EN.
module prio_mux_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [N-1:0]       sel,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [N-1:0]       grant,
  output logic               conflict,
  output logic [7:0]         conflict_cnt
);

  localparam int unsigned PW = ($clog2(N) < 1) ? 1 : $clog2(N);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     grant_q, grant_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [WIDTH-1:0] win_data;

  // Round-robin wrap scan done as two passes: first channels at/after rr_ptr,
  // then from channel 0. In fixed-priority mode the first pass covers all channels.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && sel[i] && (MODE == 0 || i >= 32'(rr_ptr_q))) begin
        found    = 1'b1;
        win      = PW'(i);
        win_data = data_in[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && sel[i]) begin
        found    = 1'b1;
        win      = PW'(i);
        win_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    out_d    = out_q;
    valid_d  = found;
    grant_d  = '0;
    if (found) begin
      out_d   = win_data;
      grant_d = N'(1) << win;
      if (MODE == 1) begin
        rr_ptr_d = (32'(win) == N - 1) ? '0 : win + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;

`ifdef PRIO_MUX_CONFLICT_EN
  logic       conflict_q;
  logic [7:0] conflict_cnt_q;
  logic       multi;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi = |(sel & (sel - N'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      conflict_q <= multi;
      if (multi && conflict_cnt_q != '1) begin
        conflict_cnt_q <= conflict_cnt_q + 8'd1;
      end
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict     = 1'b0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_prio_mux_reg.sv
// Directed bench for prio_mux_reg: one fixed-priority and one round-robin instance
// driven by the same stimulus; conflict expectations follow PRIO_MUX_CONFLICT_EN.
module tb_prio_mux_reg;

  localparam int unsigned W = 8;
  localparam int unsigned N = 3;
`ifdef PRIO_MUX_CONFLICT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] data_in;
  logic [N-1:0] sel;

  logic [W-1:0] o0, o1;
  logic         v0, v1;
  logic [N-1:0] g0, g1;
  logic         c0, c1;
  logic [7:0]   cc0, cc1;

  prio_mux_reg #(.WIDTH(W), .N(N), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
    .out(o0), .out_valid(v0), .grant(g0), .conflict(c0), .conflict_cnt(cc0)
  );

  prio_mux_reg #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
    .out(o1), .out_valid(v1), .grant(g1), .conflict(c1), .conflict_cnt(cc1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sel = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] s;
    logic [7:0] o0;
    logic [2:0] g0;
    logic [7:0] o1;
    logic [2:0] g1;
    logic       v;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] exp_cnt;

    vecs[0] = '{3'b110, 8'h22, 3'b010, 8'h22, 3'b010, 1'b1};
    vecs[1] = '{3'b000, 8'h22, 3'b000, 8'h22, 3'b000, 1'b0};
    vecs[2] = '{3'b011, 8'h11, 3'b001, 8'h11, 3'b001, 1'b1};
    vecs[3] = '{3'b111, 8'h11, 3'b001, 8'h22, 3'b010, 1'b1};
    vecs[4] = '{3'b111, 8'h11, 3'b001, 8'h33, 3'b100, 1'b1};
    vecs[5] = '{3'b111, 8'h11, 3'b001, 8'h11, 3'b001, 1'b1};
    vecs[6] = '{3'b100, 8'h33, 3'b100, 8'h33, 3'b100, 1'b1};
    vecs[7] = '{3'b010, 8'h22, 3'b010, 8'h22, 3'b010, 1'b1};
    vecs[8] = '{3'b001, 8'h11, 3'b001, 8'h11, 3'b001, 1'b1};
    vecs[9] = '{3'b000, 8'h11, 3'b000, 8'h11, 3'b000, 1'b0};

    rst     = 1'b1;
    sel     = '0;
    data_in = {8'h33, 8'h22, 8'h11};

    // Reset held with idle selects
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_out0", 32'(o0), 32'h0);
      chk("rst_out1", 32'(o1), 32'h0);
      chk("rst_valid", 32'({v0, v1}), 32'h0);
      chk("rst_grant", 32'({g0, g1}), 32'h0);
      chk("rst_conflict", 32'({c0, cc0}), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table: both modes, including wrap-and-skip at row 2 (rr_ptr=2, sel=011)
    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].s;
      step();
      chk($sformatf("vec%0d_out_fix", i), 32'(o0), 32'(vecs[i].o0));
      chk($sformatf("vec%0d_grant_fix", i), 32'(g0), 32'(vecs[i].g0));
      chk($sformatf("vec%0d_valid_fix", i), 32'(v0), 32'(vecs[i].v));
      chk($sformatf("vec%0d_out_rr", i), 32'(o1), 32'(vecs[i].o1));
      chk($sformatf("vec%0d_grant_rr", i), 32'(g1), 32'(vecs[i].g1));
      chk($sformatf("vec%0d_valid_rr", i), 32'(v1), 32'(vecs[i].v));
    end

    // Round-robin rotation from reset
    do_reset();
    sel = 3'b111;
    step(); chk("rot0_grant", 32'(g1), 32'h1); chk("rot0_out", 32'(o1), 32'h11);
    step(); chk("rot1_grant", 32'(g1), 32'h2); chk("rot1_out", 32'(o1), 32'h22);
    step(); chk("rot2_grant", 32'(g1), 32'h4); chk("rot2_out", 32'(o1), 32'h33);
    step(); chk("rot3_grant", 32'(g1), 32'h1); chk("rot3_out", 32'(o1), 32'h11);
    step(); chk("rot4_grant", 32'(g1), 32'h2);

    // Asynchronous reset between edges takes effect without a clock edge
    #3 rst = 1'b1;
    #1;
    chk("async_out", 32'({o0, o1}), 32'h0);
    chk("async_grant", 32'({g0, g1}), 32'h0);
    chk("async_valid", 32'({v0, v1}), 32'h0);
    chk("async_conflict", 32'({c0, cc0, c1, cc1}), 32'h0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_grant", 32'(g1), 32'h1);
    chk("post_rst_out", 32'(o1), 32'h11);

    // Conflict burst and saturation
    do_reset();
    sel = 3'b011;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_cnt = (i >= 254) ? 8'hFF : 8'(i + 1);
      chk($sformatf("burst%0d_conflict", i), 32'(c0), 32'(CEN));
      chk($sformatf("burst%0d_cnt", i), 32'(cc0), CEN ? 32'(exp_cnt) : 32'h0);
    end
    sel = 3'b001;
    step();
    chk("after_conflict", 32'(c0), 32'h0);
    chk("after_cnt", 32'(cc0), CEN ? 32'hFF : 32'h0);
    chk("after_cnt_rr", 32'(cc1), CEN ? 32'hFF : 32'h0);
    chk("after_grant_rr", 32'(g1), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
